mc_control_fsm: RTL and testbench

- Main sequencer for the multi-cycle RV32I core; generates all datapath selects and write enables.
- Each instruction is sequenced through fetch, decode, execute, memory and writeback states.
- IRWrite drives the enable of the paired OldPC/Instr fetch register, so both values are captured together in FETCH.
- Moore FSM with combinational ALU and immediate decoders; sits between the Instr register fields and the datapath muxes.

---
 rtl/mc_ctrl_pkg.sv | 63 ++++++
 rtl/mc_control_fsm_if.sv | 34 +++
 rtl/mc_alu_decoder.sv | 36 +++
 rtl/mc_control_fsm.sv | 154 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control sequencer
// Contents: state enum, opcode constants, ALUOp / ResultSrc / ALUSrcA / ALUSrcB /
// ImmSrc / ALUControl encodings and the opcode -> ImmSrc helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - instruction-field inputs and datapath control outputs of the sequencer
// Signals: op, funct3, funct7b5, zero (from datapath); PCWrite, AdrSrc, MemWrite, IRWrite,
// RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl (to datapath).
// Modports: master = control unit side, slave = datapath side.
interface mc_control_fsm_if #(
  parameter int ALUCTRL_W = 3
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 zero;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;

  modport master (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - combinational ALUOp/funct3/op5/funct7b5 -> ALUControl decoder
// Ports: alu_op (in, 2), funct3 (in, 3), op5 (in, 1), funct7b5 (in, 1), alu_control (out, ALUCTRL_W).
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct3,
  input  logic                 op5,
  input  logic                 funct7b5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [2:0] ctl;

  always_comb begin
    ctl = ALUC_ADD;
    case (alu_op)
      ALUOP_SUB:   ctl = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type: addi with Instr[30]=1 must still add.
          3'b000:  ctl = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  ctl = ALUC_SLT;
          3'b110:  ctl = ALUC_OR;
          3'b111:  ctl = ALUC_AND;
          default: ctl = ALUC_ADD;
        endcase
      end
      default:     ctl = ALUC_ADD;
    endcase
    alu_control = ALUCTRL_W'(ctl);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - Moore main sequencer for the multi-cycle RV32I core
// Ports: clk (in), reset (in, async active-high), bus (mc_control_fsm_if.master: instruction
// fields and zero in, datapath selects and write enables out).
// Build option: MC_CTRL_BNE_EN adds bne (funct3 001) to the branch state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int STATE_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mc_control_fsm_if.master      bus
);

  logic [STATE_W-1:0] state_q;
  state_t             state;
  state_t             state_next;

  logic [1:0] alu_op;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       pc_update;
  logic       branch;
  logic       branch_cond;
  logic [1:0] result_src;
  logic [1:0] src_a;
  logic [1:0] src_b;

  // Only the low four bits carry the enum; wider registers keep upper bits at zero.
  assign state = state_t'(state_q[3:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= STATE_W'(S_FETCH);
    else       state_q <= STATE_W'(state_next);
  end

  always_comb begin
    state_next = S_FETCH;
    alu_op     = ALUOP_ADD;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here and parked in ALUOut.
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
`ifdef MC_CTRL_BNE_EN
          OP_BEQ:       state_next = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_FETCH;
`else
          OP_BEQ:       state_next = S_BRANCH;
`endif
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_IMM;
        // Only lw and sw reach here; op[5] tells them apart.
        state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_RD2;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        src_a  = SRCA_RD1;
        src_b  = SRCB_RD2;
        alu_op = ALUOP_SUB;
        branch = 1'b1;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut; ALU forms OldPC+4 for the link write.
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

`ifdef MC_CTRL_BNE_EN
  assign branch_cond = bus.zero ^ bus.funct3[0];
`else
  assign branch_cond = bus.zero;
`endif

  // Write enables are masked while reset is held so FETCH selects can show without side effects.
  assign bus.PCWrite   = ~reset & (pc_update | (branch & branch_cond));
  assign bus.IRWrite   = ~reset & ir_write;
  assign bus.MemWrite  = ~reset & mem_write;
  assign bus.RegWrite  = ~reset & reg_write;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.ImmSrc    = imm_src_of(bus.op);

  mc_alu_decoder #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (bus.ALUControl)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized self-checking bench for mc_control_fsm against an instruction-level model
module tb_mc_control_fsm;

`ifdef MC_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] rsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [2:0] aluc;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if #(.ALUCTRL_W(3)) bus ();

  mc_control_fsm #(
    .ALUCTRL_W (3),
    .STATE_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t o;
    o.pcw  = bus.PCWrite;
    o.adr  = bus.AdrSrc;
    o.memw = bus.MemWrite;
    o.irw  = bus.IRWrite;
    o.regw = bus.RegWrite;
    o.rsrc = bus.ResultSrc;
    o.srca = bus.ALUSrcA;
    o.srcb = bus.ALUSrcB;
    o.imm  = bus.ImmSrc;
    o.aluc = bus.ALUControl;
    return o;
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] op);
    if (op == SW) return 2'b01;
    if (op == BR) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] ref_funct(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (op == RT && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == LW || op == SW || op == RT || op == IT || op == BR || op == JL;
  endfunction

  // Cycles from FETCH until the next FETCH.
  function automatic int ref_len(input logic [6:0] op, input logic [2:0] f3);
    if (op == LW) return 5;
    if (op == SW || op == RT || op == IT || op == JL) return 4;
    if (op == BR) return (BNE_EN && f3 > 3'd1) ? 2 : 3;
    return 2;
  endfunction

  // Expected controls for cycle cyc (0 = fetch) of one instruction.
  function automatic ctl_t ref_ctl(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic z, input int cyc);
    ctl_t e = '0;
    e.imm = ref_imm(op);
    if (cyc == 0) begin
      e.irw = 1; e.pcw = 1; e.srcb = 2'b10; e.rsrc = 2'b10;
    end else if (cyc == 1) begin
      e.srca = 2'b01; e.srcb = 2'b01;
    end else if (cyc == 2) begin
      if (op == LW || op == SW) begin
        e.srca = 2'b10; e.srcb = 2'b01;
      end else if (op == RT) begin
        e.srca = 2'b10; e.aluc = ref_funct(op, f3, f7);
      end else if (op == IT) begin
        e.srca = 2'b10; e.srcb = 2'b01; e.aluc = ref_funct(op, f3, f7);
      end else if (op == BR) begin
        e.srca = 2'b10; e.aluc = 3'd1;
        e.pcw  = BNE_EN ? (z ^ f3[0]) : z;
      end else if (op == JL) begin
        e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1;
      end
    end else if (cyc == 3) begin
      if (op == LW) e.adr = 1;
      else if (op == SW) begin e.adr = 1; e.memw = 1; end
      else e.regw = 1;
    end else begin
      e.rsrc = 2'b01; e.regw = 1;
    end
    return e;
  endfunction

  // Reset view: FETCH selects with every write enable low.
  function automatic ctl_t ref_reset(input logic [6:0] op);
    ctl_t e = '0;
    e.imm = ref_imm(op); e.srcb = 2'b10; e.rsrc = 2'b10;
    return e;
  endfunction

  // Runs one instruction from its FETCH cycle; zmode 0/1 forces zero, 2 randomizes it.
  // Returns just after the edge that starts the following cycle.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int zmode, input int max_cyc);
    int n = ref_len(op, f3);
    if (max_cyc < n) n = max_cyc;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
    for (int c = 0; c < n; c++) begin
      bus.zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      check_eq($sformatf("%s op=%b f3=%0d c%0d", name, op, f3, c + 1),
               32'(observe()), 32'(ref_ctl(op, f3, f7, bus.zero, c)));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [6:0] rop;
    reset = 1'b1;
    bus.op = LW; bus.funct3 = 3'd2; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("reset_hold %0d", i), 32'(observe()), 32'(ref_reset(LW)));
    end
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr("lw", LW, 3'd2, 1'b0, 2, 99);
    run_instr("sw", SW, 3'd2, 1'b0, 2, 99);
    run_instr("sub", RT, 3'd0, 1'b1, 2, 99);
    run_instr("addi_f7", IT, 3'd0, 1'b1, 2, 99);
    run_instr("beq_z1", BR, 3'd0, 1'b0, 1, 99);
    run_instr("beq_z0", BR, 3'd0, 1'b0, 0, 99);
    run_instr("bne_z0", BR, 3'd1, 1'b0, 0, 99);
    run_instr("bne_z1", BR, 3'd1, 1'b0, 1, 99);
    run_instr("blt", BR, 3'd4, 1'b0, 1, 99);
    run_instr("jal", JL, 3'd0, 1'b0, 2, 99);
    run_instr("illegal", 7'b1111111, 3'd0, 1'b0, 2, 99);

    // Abort a lw just as it enters MEMWB: no register write may escape.
    run_instr("lw_abort", LW, 3'd2, 1'b0, 2, 4);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_in_reset", 32'(observe()), 32'(ref_reset(LW)));
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr("after_abort", RT, 3'd7, 1'b0, 2, 99);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IT;
        4: rop = BR;
        5: rop = JL;
        default: begin
          rop = 7'($urandom);
          if (is_legal(rop)) rop = 7'b1111111;
        end
      endcase
      run_instr("rand", rop, 3'($urandom), 1'($urandom), 2, 99);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
